// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - memory request/response bus shared by the CPU, DMA and downstream ports
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0]    width;
  logic          read;
  logic          write;
  logic [DW-1:0] rdata;
  logic          ok;

  // The requester drives the access and receives the completion.
  modport master (
    output addr, wdata, width, read, write,
    input  rdata, ok
  );

  // The responder receives the access and drives the completion.
  modport slave (
    input  addr, wdata, width, read, write,
    output rdata, ok
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (CPU/DMA) non-preemptive memory arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  cpu,
  mem_arbiter_if.slave  dma,
  mem_arbiter_if.master mem,
  output logic [1:0]    grant
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_CPU = 2'd1;
  localparam logic [1:0] BUSY_DMA = 2'd2;

  logic [1:0]    state;
  logic          last_grant;   // 1 = DMA was granted last, 0 = CPU
  logic          cpu_req;
  logic          dma_req;
  logic          pick_dma;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    sel_width;
  logic          sel_read;
  logic          sel_write;

  assign cpu_req = cpu.read | cpu.write;
  assign dma_req = dma.read | dma.write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Tie goes to whichever master did not win last; reset value DMA hands the first tie to the CPU.
  always_comb begin
    pick_dma = 1'b0;
    if (dma_req && (!cpu_req || !last_grant)) pick_dma = 1'b1;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Fixed priority: DMA wins every tie, the CPU may be starved.
  always_comb begin
    pick_dma = 1'b0;
    if (dma_req) pick_dma = 1'b1;
  end
`endif

  // Mux the winning master's request fields toward the downstream registers.
  always_comb begin
    sel_addr  = cpu.addr;
    sel_wdata = cpu.wdata;
    sel_width = cpu.width;
    sel_read  = cpu.read;
    sel_write = cpu.write;
    if (pick_dma) begin
      sel_addr  = dma.addr;
      sel_wdata = dma.wdata;
      sel_width = dma.width;
      sel_read  = dma.read;
      sel_write = dma.write;
    end
  end

  // Arbitration FSM: latch the winner in IDLE, hold it until mem_ok, then return to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      mem.addr   <= '0;
      mem.wdata  <= '0;
      mem.width  <= 2'd2;
      mem.read   <= 1'b0;
      mem.write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            mem.addr  <= sel_addr;
            mem.wdata <= sel_wdata;
            mem.width <= sel_width;
            mem.read  <= sel_read;
            // Read wins when both strobes are set; the write is dropped.
            mem.write <= sel_write & ~sel_read;
            state     <= pick_dma ? BUSY_DMA : BUSY_CPU;
          end
        end
        BUSY_CPU, BUSY_DMA: begin
          if (mem.ok) begin
            mem.read   <= 1'b0;
            mem.write  <= 1'b0;
            last_grant <= (state == BUSY_DMA);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion and read data go combinationally to the granted master only.
  assign cpu.ok    = (state == BUSY_CPU) & mem.ok;
  assign dma.ok    = (state == BUSY_DMA) & mem.ok;
  assign cpu.rdata = (state == BUSY_CPU) ? mem.rdata : '0;
  assign dma.rdata = (state == BUSY_DMA) ? mem.rdata : '0;
  assign grant     = {state == BUSY_DMA, state == BUSY_CPU};
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter (MEM_ARB_ROUND_ROBIN_EN aware)
module tb_mem_arbiter;
  typedef struct {
    bit          dma;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    bit          rd;
    bit          wr;
  } iss_t;

  typedef struct {
    bit          dma;
    logic [31:0] rdata;
  } cmp_t;

  logic       clk;
  logic       rstn;
  logic [1:0] grant;

  mem_arbiter_if #(.AW(32), .DW(32)) cpu_if ();
  mem_arbiter_if #(.AW(32), .DW(32)) dma_if ();
  mem_arbiter_if #(.AW(32), .DW(32)) mem_if ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .cpu   (cpu_if),
    .dma   (dma_if),
    .mem   (mem_if),
    .grant (grant)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cycles = 0;
  int comp_count = 0;
  int last_ok_cyc = 0;
  int last_gap = 0;
  bit resp_en = 1'b1;
  int lat = 1;
  logic [31:0] resp_data = 32'h0;
  iss_t issue_q[$];
  cmp_t comp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic iss_t mk_iss(input bit d, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [1:0] w, input bit r, input bit wr);
    iss_t t;
    t.dma = d; t.addr = a; t.wdata = wd; t.width = w; t.rd = r; t.wr = wr;
    return t;
  endfunction

  function automatic cmp_t mk_cmp(input bit d, input logic [31:0] rd);
    cmp_t t;
    t.dma = d; t.rdata = rd;
    return t;
  endfunction

  // Downstream memory model: answers lat cycles after the access appears.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) cnt = 0;
      else if (mem_if.ok) begin
        mem_if.ok = 1'b0;
        cnt = 0;
      end else if (mem_if.read || mem_if.write) begin
        cnt++;
        if (cnt >= lat) begin
          mem_if.ok    = 1'b1;
          mem_if.rdata = resp_data;
        end
      end
    end
  end

  // Monitor: checks each new grant against issue_q, holds mem_* stable, and checks each ok against comp_q.
  initial begin
    logic [1:0] prev_grant;
    iss_t cur;
    iss_t e;
    cmp_t c;
    prev_grant = 2'b00;
    cur = mk_iss(0, 0, 0, 0, 0, 0);
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_if.read) rd_cycles++;
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        last_gap = cyc - last_ok_cyc;
        if (issue_q.size() == 0) chk("unexpected_grant", {62'd0, grant}, 64'd0);
        else begin
          e = issue_q.pop_front();
          cur = e;
          chk("iss_grant", {62'd0, grant}, e.dma ? 64'd2 : 64'd1);
          chk("iss_addr", {32'd0, mem_if.addr}, {32'd0, e.addr});
          chk("iss_wdata", {32'd0, mem_if.wdata}, {32'd0, e.wdata});
          chk("iss_width", {62'd0, mem_if.width}, {62'd0, e.width});
          chk("iss_rw", {62'd0, mem_if.read, mem_if.write}, {62'd0, e.rd, e.wr});
        end
      end else if (grant != 2'b00) begin
        chk("hold_mem", {mem_if.addr, mem_if.wdata},{cur.addr, cur.wdata});
        chk("hold_ctl", {59'd0, mem_if.width, mem_if.read, mem_if.write},
            {59'd0, cur.width, cur.rd, cur.wr});
      end
      if (cpu_if.ok || dma_if.ok) begin
        last_ok_cyc = cyc;
        comp_count++;
        if (comp_q.size() == 0) chk("unexpected_ok", {62'd0, dma_if.ok, cpu_if.ok}, 64'd0);
        else begin
          c = comp_q.pop_front();
          chk("ok_who", {62'd0, dma_if.ok, cpu_if.ok}, c.dma ? 64'd2 : 64'd1);
          chk("ok_rdata", {32'd0, c.dma ? dma_if.rdata : cpu_if.rdata}, {32'd0, c.rdata});
          chk("other_rdata", {32'd0, c.dma ? cpu_if.rdata : dma_if.rdata}, 64'd0);
        end
      end
      prev_grant = grant;
    end
  end

  task automatic drive(input bit is_dma, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] w);
    if (is_dma) begin
      dma_if.read = rd; dma_if.write = wr; dma_if.addr = a; dma_if.wdata = d; dma_if.width = w;
    end else begin
      cpu_if.read = rd; cpu_if.write = wr; cpu_if.addr = a; cpu_if.wdata = d; cpu_if.width = w;
    end
  endtask

  // One master transaction: raise strobes, hold until that master's ok (bounded), then drop.
  task automatic txn(input bit is_dma, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] w);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    drive(is_dma, rd, wr, a, d, w);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (is_dma ? dma_if.ok : cpu_if.ok) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk(is_dma ? "dma_timeout" : "cpu_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    drive(is_dma, 1'b0, 1'b0, a, d, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base;
    bit done;
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    mem_if.ok = 1'b0;
    mem_if.rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_addr", {32'd0, mem_if.addr}, 64'd0);
    chk("rst_wdata", {32'd0, mem_if.wdata}, 64'd0);
    chk("rst_width", {62'd0, mem_if.width}, 64'd2);
    chk("rst_rw", {62'd0, mem_if.read, mem_if.write}, 64'd0);
    chk("rst_grant", {62'd0, grant}, 64'd0);
    chk("rst_ok", {62'd0, dma_if.ok, cpu_if.ok}, 64'd0);
    chk("rst_rdata", {cpu_if.rdata, dma_if.rdata}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    mem_if.rdata = 32'h0;

    // CPU-only read, memory answers 3 cycles after grant.
    lat = 3;
    resp_data = 32'hE3A0_0013;
    issue_q.push_back(mk_iss(0, 32'h0800_0000, 32'h0, 2'd2, 1, 0));
    comp_q.push_back(mk_cmp(0, 32'hE3A0_0013));
    rd_cycles = 0;
    txn(1'b0, 1'b1, 1'b0, 32'h0800_0000, 32'h0, 2'd2);
    @(negedge clk);
    chk("cpu_rd_cycles", rd_cycles, 64'd3);

    // DMA-only halfword write, immediate answer.
    lat = 1;
    resp_data = 32'h0;
    issue_q.push_back(mk_iss(1, 32'h0300_0010, 32'hDEAD_BEEF, 2'd1, 0, 1));
    comp_q.push_back(mk_cmp(1, 32'h0));
    txn(1'b1, 1'b0, 1'b1, 32'h0300_0010, 32'hDEAD_BEEF, 2'd1);
    @(negedge clk);
    chk("dma_wr_idle", {61'd0, grant, mem_if.write}, 64'd0);

    // Continuous contention for four transactions.
    resp_data = 32'hA5A5_0001;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      issue_q.push_back(i % 2 == 0 ? mk_iss(0, 32'h100, 32'h0, 2'd2, 1, 0)
                                   : mk_iss(1, 32'h200, 32'h0, 2'd2, 1, 0));
      comp_q.push_back(mk_cmp(i % 2 == 1, 32'hA5A5_0001));
    end
`else
    for (int i = 0; i < 4; i++) begin
      issue_q.push_back(mk_iss(1, 32'h200, 32'h0, 2'd2, 1, 0));
      comp_q.push_back(mk_cmp(1, 32'hA5A5_0001));
    end
`endif
    base = comp_count;
    done = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
    drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 2'd2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (comp_count == base + 4) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("tie_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    repeat (2) @(negedge clk);

    // DMA arrives while BUSY_CPU; CPU values must hold, DMA granted after one IDLE cycle.
    lat = 4;
    resp_data = 32'h1234_5678;
    issue_q.push_back(mk_iss(0, 32'h0000_0100, 32'h0, 2'd2, 1, 0));
    issue_q.push_back(mk_iss(1, 32'h0000_0200, 32'h55, 2'd0, 0, 1));
    comp_q.push_back(mk_cmp(0, 32'h1234_5678));
    comp_q.push_back(mk_cmp(1, 32'h1234_5678));
    fork
      txn(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'd2);
      begin
        repeat (2) @(posedge clk);
        txn(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h55, 2'd0);
      end
    join
    chk("dma_after_cpu_gap", last_gap, 64'd2);

    // Reset pulse mid BUSY_DMA, then a stray mem_ok.
    resp_en = 1'b0;
    issue_q.push_back(mk_iss(1, 32'h0000_0300, 32'h0, 2'd2, 1, 0));
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 2'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_read", {62'd0, grant, mem_if.read}, {62'd0, 2'b10, 1'b1});
    #2;
    rstn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    #1;
    chk("async_rst_read", {63'd0, mem_if.read}, 64'd0);
    chk("async_rst_grant", {62'd0, grant}, 64'd0);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    mem_if.ok = 1'b1;
    mem_if.rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late_ok_ignored", {62'd0, dma_if.ok, cpu_if.ok}, 64'd0);
    chk("late_ok_grant", {62'd0, grant}, 64'd0);
    @(posedge clk);
    #1;
    mem_if.ok = 1'b0;
    @(negedge clk);
    chk("late_ok_state", {62'd0, grant}, 64'd0);
    resp_en = 1'b1;

    // CPU read and write together: read issued, write dropped.
    lat = 2;
    resp_data = 32'h0BAD_F00D;
    issue_q.push_back(mk_iss(0, 32'h0400_0000, 32'h7777, 2'd2, 1, 0));
    comp_q.push_back(mk_cmp(0, 32'h0BAD_F00D));
    txn(1'b0, 1'b1, 1'b1, 32'h0400_0000, 32'h7777, 2'd2);
    repeat (2) @(negedge clk);

    chk("issue_q_empty", issue_q.size(), 64'd0);
    chk("comp_q_empty", comp_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master memory bus arbiter between the ARMv4T core's memory port and the DMA engine's memory port. It shares one downstream memory interface (ROM/RAM/IO decoder). It latches the winning request, holds it stable downstream until the memory completes, and routes completion and read data back to the granted master only. Each transaction is non-preemptive.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  input  1  clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- cpu_addr  input  AW  CPU request address
- cpu_wdata  input  DW  CPU write data
- cpu_width  input  2  CPU access size log2 (0 byte, 1 half, 2 word)
- cpu_read / cpu_write  input  1  CPU request strobes, held until cpu_ok
- cpu_rdata  output  DW  read data to CPU
- cpu_ok  output  1  CPU transaction complete
- dma_addr, dma_wdata, dma_width, dma_read, dma_write  input  (AW, DW, 2, 1, 1)  DMA request, same rules as CPU
- dma_rdata  output  DW  read data to DMA
- dma_ok  output  1  DMA transaction complete
- mem_addr  output  AW  downstream address (registered)
- mem_wdata  output  DW  downstream write data (registered)
- mem_width  output  2  downstream size (registered)
- mem_read / mem_write  output  1  downstream strobes (registered)
- mem_rdata  input  DW  downstream read data
- mem_ok  input  1  downstream completion, single-cycle pulse
- grant  output  2  {dma_granted, cpu_granted}, one-hot or zero

## Operation
- States: IDLE, BUSY_CPU, BUSY_DMA.
- A master requests when its read or its write strobe is high. If both strobes are high, the request is treated as a read and the write is dropped.
- IDLE, exactly one master requesting: latch that master's addr, wdata, width, read and write into the mem_* registers, then go to BUSY_x.
- IDLE, both masters requesting: the tie-break rule (see Configuration) selects the winner. The loser's request stays pending and is not latched.
- BUSY_x: mem_* registers hold constant and ignore all master inputs.
  - x_ok = mem_ok and x_rdata = mem_rdata, both combinational.
  - The other master's ok is 0 and its rdata is 0.
- BUSY_x with mem_ok = 1: clear mem_read and mem_write, record last_grant = x, and return to IDLE on the same edge.
- A master that drops its strobes while granted does not abort the transfer. The downstream access completes and its ok pulse is still driven.
- grant reflects the state: 2'b01 in BUSY_CPU, 2'b10 in BUSY_DMA, 2'b00 in IDLE.
- Reset values: state IDLE, mem_addr 0, mem_wdata 0, mem_width 2, mem_read 0, mem_write 0, last_grant DMA, grant 0, cpu_ok 0, dma_ok 0, rdata outputs 0.
- Reset asserted mid-transaction forces IDLE and deasserts mem_read/mem_write immediately, without waiting for a clock edge. A late mem_ok after reset is ignored.
- mem_ok arriving in IDLE is ignored.

## Timing
- Request seen in IDLE at edge N: mem_* are valid from edge N+1.
- Completion: the ok pulse appears in the same cycle as mem_ok.
- Minimum transaction is 2 cycles: 1 arbitration cycle plus 1 cycle if the memory answers immediately.
- Back-to-back: after completion the state is IDLE for at least one cycle before the next grant. Per-transaction overhead is fixed at 1 cycle.
- A request that arrives while BUSY waits for IDLE. Worst-case wait for a master is one full transaction of the other master plus 1 cycle, under round-robin.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, the master not equal to last_grant wins.
  - The first tie after reset goes to the CPU.
  - Under continuous contention the masters alternate.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, DMA always wins a tie.
  - last_grant is still maintained but unused.
  - The CPU can be starved while DMA requests continuously. This matches GBA DMA halting the CPU.

## Test plan
- CPU-only read: cpu_read with cpu_addr=0x08000000 and width 2; memory returns mem_rdata=0xE3A00013 with mem_ok 3 cycles after grant.
  - Required: mem_read high for exactly those cycles, cpu_rdata=0xE3A00013 with cpu_ok in the mem_ok cycle, grant=01, dma_ok stays 0.
- DMA-only write: dma_write with addr=0x03000010, wdata=0xDEADBEEF, width 1.
  - Required: mem_write=1 with the same values from the next edge, dma_ok with mem_ok, then IDLE.
- Simultaneous requests held continuously, memory ok after 1 cycle.
  - Fixed priority: DMA granted every time, cpu_ok never asserts.
  - With MEM_ARB_ROUND_ROBIN_EN: grant sequence CPU, DMA, CPU, DMA.
- DMA request arriving while BUSY_CPU: the mem_* values stay those of the CPU until mem_ok, and DMA is granted on the edge after IDLE.
- Reset pulse while BUSY_DMA with mem_read high: mem_read is 0 within the reset-low cycle without a clock edge, the state is IDLE, and a mem_ok pulse one cycle later produces no ok to either master.
- CPU asserting read and write together with addr 0x04000000: a downstream read is issued and mem_write stays 0.
